// File: rtl/fp32_pkg.sv
// Shared fp32 constants and payload types for the normalize/round datapath.
package fp32_pkg;

    localparam int unsigned FP32_BIAS    = 127;
    localparam int unsigned FP32_EXP_MAX = 255;
    localparam int unsigned FP32_FRAC_W  = 23;
    localparam int unsigned NORM_FRAC_W  = 48;
    localparam int unsigned NORM_EXP_W   = 9;

    // Result classification flags carried alongside the normalized value.
    typedef struct packed {
        logic zero;
        logic overflow;
        logic underflow;
    } norm_flags_t;

endpackage : fp32_pkg

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields W.
module fp_lzc #(
    parameter int unsigned W     = 49,
    parameter int unsigned CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     i_data,
    output logic [CNT_W-1:0] o_lz_c
);

    logic w_found;

    // Scan from the MSB; the first set bit fixes the count.
    always_comb begin
        o_lz_c  = CNT_W'(W);
        w_found = 1'b0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (!w_found && i_data[i]) begin
                o_lz_c  = CNT_W'(int'(W) - 1 - i);
                w_found = 1'b1;
            end
        end
    end

endmodule : fp_lzc

// File: rtl/fp32_normalize.sv
// Two-stage normalizer ahead of fp32 rounding: S1 counts leading zeros,
// S2 left-aligns the fraction, folds sticky bits and classifies the exponent.
module fp32_normalize
    import fp32_pkg::*;
#(
    parameter int unsigned IN_W  = 49,
    parameter int unsigned EXP_W = 10
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic                   sign_in,
    input  logic [EXP_W-1:0]       exp_in,
    input  logic [IN_W-1:0]        frac_in,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   sign_out,
    output logic [NORM_EXP_W-1:0]  normalized_exp_out,
    output logic [NORM_FRAC_W-1:0] normalized_frac_out,
    output logic                   zero_out,
    output logic                   overflow_out,
    output logic                   underflow_out
);

    localparam int unsigned LZ_W = $clog2(IN_W + 1);
    localparam int unsigned E_W  = EXP_W + 1;

    // S1 registers
    logic                    r_s1_valid;
    logic                    r_s1_sign;
    logic signed [EXP_W-1:0] r_s1_exp;
    logic [IN_W-1:0]         r_s1_frac;
    logic [LZ_W-1:0]         r_s1_lz;
    logic                    r_s1_zero;

    // S2 (output) registers
    logic                    r_s2_valid;
    logic                    r_s2_sign;
    logic [NORM_EXP_W-1:0]   r_s2_exp;
    logic [NORM_FRAC_W-1:0]  r_s2_frac;
    norm_flags_t             r_s2_flags;

    // Combinational nets
    logic                    w_s2_ready;
    logic                    w_in_fire;
    logic [LZ_W-1:0]         w_lz;
    logic [IN_W-1:0]         w_shifted;
    logic signed [E_W-1:0]   w_exp_ext;
    logic signed [E_W-1:0]   w_lz_ext;
    logic signed [E_W-1:0]   w_e;
    logic [NORM_EXP_W-1:0]   w_exp_n;
    logic [NORM_FRAC_W-1:0]  w_frac_n;
    norm_flags_t             w_flags_n;

    // Stage handshake: ready depends only on downstream state, never on valid_in.
    assign w_s2_ready = !r_s2_valid || ready_in;
    assign ready_out  = !r_s1_valid || w_s2_ready;
    assign w_in_fire  = valid_in && ready_out;

    fp_lzc #(
        .W     (IN_W),
        .CNT_W (LZ_W)
    ) u_lzc (
        .i_data (frac_in),
        .o_lz_c (w_lz)
    );

    // S1: capture operand and its leading-zero count.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_frac  <= '0;
            r_s1_lz    <= '0;
            r_s1_zero  <= 1'b0;
        end else if (ready_out) begin
            r_s1_valid <= valid_in;
            if (w_in_fire) begin
                r_s1_sign <= sign_in;
                r_s1_exp  <= $signed(exp_in);
                r_s1_frac <= frac_in;
                r_s1_lz   <= w_lz;
                r_s1_zero <= (frac_in == '0);
            end
        end
    end

    // S2 datapath: align leading one to the MSB and rebias the exponent.
    assign w_shifted = r_s1_frac << r_s1_lz;
    assign w_exp_ext = E_W'(r_s1_exp);
    assign w_lz_ext  = $signed(E_W'(r_s1_lz));
    assign w_e       = w_exp_ext - w_lz_ext + $signed(E_W'(1));

    // S2 classification: zero, underflow flush, overflow saturate, or normal.
    always_comb begin
        w_exp_n   = w_e[NORM_EXP_W-1:0];
        w_frac_n  = {w_shifted[IN_W-1:2], w_shifted[1] | w_shifted[0]};
        w_flags_n = '0;
        if (r_s1_zero) begin
            w_exp_n        = '0;
            w_frac_n       = '0;
            w_flags_n.zero = 1'b1;
        end else if (w_e <= $signed(E_W'(0))) begin
            w_exp_n             = '0;
            w_frac_n            = '0;
            w_flags_n.zero      = 1'b1;
            w_flags_n.underflow = 1'b1;
        end else if (w_e >= $signed(E_W'(FP32_EXP_MAX))) begin
            w_exp_n            = NORM_EXP_W'(FP32_EXP_MAX);
            w_frac_n           = '0;
            w_flags_n.overflow = 1'b1;
        end
    end

    // S2 registers: load only when the output slot is free or being drained.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_frac  <= '0;
            r_s2_flags <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign  <= r_s1_sign;
                r_s2_exp   <= w_exp_n;
                r_s2_frac  <= w_frac_n;
                r_s2_flags <= w_flags_n;
            end
        end
    end

    assign valid_out           = r_s2_valid;
    assign sign_out            = r_s2_sign;
    assign normalized_exp_out  = r_s2_exp;
    assign normalized_frac_out = r_s2_frac;
    assign zero_out            = r_s2_flags.zero;
    assign overflow_out        = r_s2_flags.overflow;
    assign underflow_out       = r_s2_flags.underflow;

endmodule : fp32_normalize

// File: doc/fp32_normalize.md
Name: fp32_normalize

Overview:
- Pipelined normalizer directly upstream of the fp32 rounding stage.
- Takes a raw 10-bit signed biased exponent and a 49-bit unnormalized magnitude from the multiplier or adder datapath.
- Left-aligns the leading one to bit 47 of a 48-bit fraction, with the hidden bit at 47 and sticky bits folded into bit 0, and adjusts the exponent to match.
- Flushes underflow to zero, saturates overflow to infinity, and adds valid/ready flow control so the datapath can stall.

Parameters:
- IN_W, 49, input magnitude width; bit IN_W-1 is the carry/overflow bit.
- EXP_W, 10, input exponent width, two's complement, biased by 127.

Ports:
- clk_in  input  1  clock, all logic on rising edge
- rst_in  input  1  synchronous, active-low reset
- valid_in  input  1  upstream data valid
- ready_out  output  1  block can accept data this cycle
- sign_in  input  1  result sign, passed through
- exp_in  input  EXP_W  signed biased exponent; a magnitude with its leading one at bit 47 has true exponent exp_in
- frac_in  input  IN_W  unnormalized magnitude
- valid_out  output  1  output data valid
- ready_in  input  1  downstream accepts data
- sign_out  output  1  registered sign
- normalized_exp_out  output  9  biased exponent, 0..255, bit 8 always 0
- normalized_frac_out  output  48  leading one at bit 47; bit 0 = OR of all discarded bits
- zero_out  output  1  result is exact zero or flushed underflow
- overflow_out  output  1  exponent saturated to 255
- underflow_out  output  1  nonzero input flushed to zero

Behaviour:
- Structure: 2-stage pipeline, S1 = leading-zero count, S2 = shift and adjust. Latency 2 cycles when not stalled; throughput 1 per cycle.
- Handshake, per stage: a stage is ready when it is empty or its consumer takes its data this cycle.
  - ready_out = !s1_valid || s2_ready; s2_ready = !valid_out || ready_in.
  - Transfer occurs only when valid && ready. While valid_out && !ready_in, all output registers hold stable.
  - ready_out is combinational from ready_in, with no combinational path from valid_in.
- S1: lz = number of leading zeros of frac_in counted from bit IN_W-1, range 0..49. Register sign, exp_in, frac_in, lz and is_zero = (frac_in == 0).
- S2:
  - shifted = frac << lz, IN_W bits; the leading one lands at bit 48.
  - normalized_frac_out = {shifted[48:2], shifted[1] | shifted[0]}.
  - e = exp_in + 1 - lz, computed at 11-bit signed width with no wrap.
- S2 output cases:
  - is_zero: exp = 0, frac = 0, zero_out = 1; overflow_out and underflow_out = 0.
  - e <= 0: exp = 0, frac = 0, zero_out = 1, underflow_out = 1. No subnormals.
  - e >= 255: exp = 255, frac = 0, overflow_out = 1.
  - Otherwise: exp = e[8:0], flags = 0.
  - sign is always passed through unchanged, including for zero and infinity.
- Reset, while rst_in is low at a clock edge:
  - valid_out = 0, internal s1_valid = 0.
  - sign_out = 0, normalized_exp_out = 0, normalized_frac_out = 0, all flags = 0.
  - In-flight data is discarded, including reset asserted mid-stall.
  - ready_out = 1 from the first cycle after reset releases.
- Simultaneous events:
  - A new input accepted while S2 drains in the same cycle is a legal full-rate transfer.
  - When S2 is stalled and S1 is full, ready_out = 0 and the input must be held by upstream.
- Output feeds the rounding stage unchanged. Exponent bump on rounding carry-out is the rounding stage's job, not this block's.

Decomposition:
- Shared package fp32_pkg:
  - FP32_BIAS = 127, FP32_EXP_MAX = 255, FP32_FRAC_W = 23, NORM_FRAC_W = 48.
  - typedef norm_flags_t = struct {zero, overflow, underflow}.
- One sub-module, fp_lzc: parameterized combinational leading-zero counter, width IN_W, output width $clog2(IN_W+1). Instantiated in S1.

Test Plan:
- Multiplier-style input: frac_in = 49'h0_8000_0000_0000 (bit 47 set), exp_in = 127 → after 2 cycles exp = 127, frac = 48'h8000_0000_0000, flags 0.
- Carry input: frac_in bit 48 set plus bit 0 set, exp_in = 130 → exp = 131, frac = 48'h8000_0000_0001 (sticky in bit 0).
- Cancellation: frac_in = 49'h1 (lz = 48), exp_in = 100 → e = 53; exp = 53, frac = 48'h8000_0000_0000. Same input with exp_in = 40 → exp = 0, frac = 0, zero_out = 1, underflow_out = 1.
- Overflow and zero:
  - frac_in bit 48 set, exp_in = 254 → exp = 255, frac = 0, overflow_out = 1.
  - frac_in = 0 with any exp_in → exp = 0, frac = 0, zero_out = 1, underflow_out = 0, sign preserved.
- Backpressure: stream 5 back-to-back inputs and hold ready_in = 0 for 3 cycles mid-stream → ready_out falls once S1 and S2 are full, outputs stay stable while stalled, all 5 results arrive in order with none lost or duplicated.
- Reset mid-operation: assert rst_in = 0 with both stages full → next cycle valid_out = 0 and all outputs 0; after release, first new input appears 2 cycles later.
